// File: rtl/cnn_mac_acc.sv
// cnn_mac_acc: CI-channel MAC pipeline accumulating TAPS beats, plus bias, ReLU and output saturation
// Ports: clk/reset_n (async active-low); i_clr soft clear; i_valid/i_ready input beats carrying i_data,
// i_weight, i_bias; o_valid/o_ready result handshake carrying o_data and o_sat (clipped flag).
module cnn_mac_acc #(
  parameter int CI      = 3,
  parameter int IN_BW   = 8,
  parameter int W_BW    = 8,
  parameter int TAPS    = 9,
  parameter int BIAS_BW = 16,
  parameter int OUT_BW  = 16,
  parameter int RELU_EN = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_clr,
  input  logic                  i_valid,
  output logic                  i_ready,
  input  logic [CI*IN_BW-1:0]   i_data,
  input  logic [CI*W_BW-1:0]    i_weight,
  input  logic [BIAS_BW-1:0]    i_bias,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic [OUT_BW-1:0]     o_data,
  output logic                  o_sat
);
  localparam int MUL_BW = IN_BW + W_BW;
  localparam int SUM_BW = MUL_BW + $clog2(CI);
  localparam int A1     = SUM_BW + $clog2(TAPS) + 1;
  localparam int ACC_BW = (A1 > BIAS_BW + 1) ? A1 : BIAS_BW + 1;
  localparam int XW     = ((ACC_BW > OUT_BW) ? ACC_BW : OUT_BW) + 1;
  localparam int TW     = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic signed [XW-1:0] MAXV = {{(XW-OUT_BW+1){1'b0}}, {(OUT_BW-1){1'b1}}};
  localparam logic signed [XW-1:0] MINV = {{(XW-OUT_BW+1){1'b1}}, {(OUT_BW-1){1'b0}}};

  logic                      en, first, last, sat_d;
  logic                      s1_valid_q, s2_valid_q, o_valid_q, o_sat_q;
  logic signed [MUL_BW-1:0]  prod_d [CI];
  logic signed [MUL_BW-1:0]  s1_prod_q [CI];
  logic signed [BIAS_BW-1:0] s1_bias_q, s2_bias_q, bias_q, bias_sel;
  logic signed [SUM_BW-1:0]  sum_d, s2_sum_q;
  logic signed [ACC_BW-1:0]  acc_q, acc_in, sum_x, bias_x, tot, rl;
  logic signed [XW-1:0]      rx;
  logic [TW-1:0]             tap_q;
  logic [OUT_BW-1:0]         out_d, o_data_q;

  assign en      = ~o_valid_q | o_ready;
  assign i_ready = en & ~i_clr;
  assign o_valid = o_valid_q;
  assign o_data  = o_data_q;
  assign o_sat   = o_sat_q;

  for (genvar c = 0; c < CI; c++) begin : g_mul
    assign prod_d[c] = $signed(i_data[c*IN_BW +: IN_BW]) * $signed(i_weight[c*W_BW +: W_BW]);
  end

  // The bias rides down the pipe with each beat; stage 3 keeps the copy that arrived with tap 0,
  // so a following group's tap 0 entering stage 1 cannot overwrite the bias still in use.
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < CI; i++) sum_d = sum_d + SUM_BW'(s1_prod_q[i]);
    first    = tap_q == '0;
    last     = tap_q == TW'(TAPS - 1);
    bias_sel = first ? s2_bias_q : bias_q;
    acc_in   = first ? '0 : acc_q;
    sum_x    = ACC_BW'(s2_sum_q);
    bias_x   = ACC_BW'(bias_sel);
    tot      = acc_in + sum_x + bias_x;
    rl       = (RELU_EN != 0 && tot[ACC_BW-1]) ? '0 : tot;
    rx       = XW'(rl);
    sat_d    = (rx > MAXV) || (rx < MINV);
    out_d    = rx > MAXV ? MAXV[OUT_BW-1:0] : rx < MINV ? MINV[OUT_BW-1:0] : rx[OUT_BW-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      o_valid_q  <= 1'b0;
      o_sat_q    <= 1'b0;
      o_data_q   <= '0;
      s1_prod_q  <= '{default: '0};
      s1_bias_q  <= '0;
      s2_bias_q  <= '0;
      s2_sum_q   <= '0;
      bias_q     <= '0;
      acc_q      <= '0;
      tap_q      <= '0;
    end else if (i_clr) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      o_valid_q  <= 1'b0;
      tap_q      <= '0;
    end else if (en) begin
      s1_valid_q <= i_valid;
      s1_prod_q  <= prod_d;
      s1_bias_q  <= i_bias;
      s2_valid_q <= s1_valid_q;
      s2_sum_q   <= sum_d;
      s2_bias_q  <= s1_bias_q;
      o_valid_q  <= s2_valid_q & last;
      if (s2_valid_q && last) begin
        tap_q    <= '0;
        o_data_q <= out_d;
        o_sat_q  <= sat_d;
      end else if (s2_valid_q) begin
        tap_q  <= tap_q + 1'b1;
        acc_q  <= first ? sum_x : acc_q + sum_x;
        bias_q <= first ? s2_bias_q : bias_q;
      end
    end
  end
endmodule

// File: tb/tb_cnn_mac_acc.sv
// tb_cnn_mac_acc: directed checks of cnn_mac_acc in TAPS=2 (ReLU on/off), TAPS=9 and TAPS=1 builds
module tb_cnn_mac_acc;
  logic clk = 0, reset_n = 0, i_clr = 0, i_valid = 0, o_ready = 1;
  logic [23:0] i_data = '0, i_weight = '0;
  logic [15:0] i_bias = '0;
  logic [3:0] i_ready, o_valid, o_sat;
  logic signed [15:0] od [4];
  int tests = 0, fails = 0;
  int cnt9, vals9[8], sats9[8], idx9[8];

  always #5 clk = ~clk;

  cnn_mac_acc #(.TAPS(2), .RELU_EN(1)) d2 (.clk(clk), .reset_n(reset_n), .i_clr(i_clr), .i_valid(i_valid),
    .i_ready(i_ready[0]), .i_data(i_data), .i_weight(i_weight), .i_bias(i_bias), .o_valid(o_valid[0]),
    .o_ready(o_ready), .o_data(od[0]), .o_sat(o_sat[0]));
  cnn_mac_acc #(.TAPS(2), .RELU_EN(0)) d2n (.clk(clk), .reset_n(reset_n), .i_clr(i_clr), .i_valid(i_valid),
    .i_ready(i_ready[1]), .i_data(i_data), .i_weight(i_weight), .i_bias(i_bias), .o_valid(o_valid[1]),
    .o_ready(o_ready), .o_data(od[1]), .o_sat(o_sat[1]));
  cnn_mac_acc #(.TAPS(9)) d9 (.clk(clk), .reset_n(reset_n), .i_clr(i_clr), .i_valid(i_valid),
    .i_ready(i_ready[2]), .i_data(i_data), .i_weight(i_weight), .i_bias(i_bias), .o_valid(o_valid[2]),
    .o_ready(o_ready), .o_data(od[2]), .o_sat(o_sat[2]));
  cnn_mac_acc #(.TAPS(1)) d1 (.clk(clk), .reset_n(reset_n), .i_clr(i_clr), .i_valid(i_valid),
    .i_ready(i_ready[3]), .i_data(i_data), .i_weight(i_weight), .i_bias(i_bias), .o_valid(o_valid[3]),
    .o_ready(o_ready), .o_data(od[3]), .o_sat(o_sat[3]));

  typedef struct {
    logic [23:0] d1, w1, d2, w2;
    int bias, e_r, s_r, e_n, s_n;
  } vec_t;
  vec_t tbl[6];

  function automatic logic [23:0] pack3(input int a, input int b, input int c);
    return {c[7:0], b[7:0], a[7:0]};
  endfunction

  function automatic int expg(input int g);
    int s = 100 * g;
    for (int t = 0; t < 9; t++) s += 2 * (t + 1) + 3 * g - 4;
    return s;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [23:0] d, input logic [23:0] w, input int b);
    i_data = d;
    i_weight = w;
    i_bias = 16'(b);
    i_valid = 1;
  endtask

  task automatic clr_pulse();
    i_valid = 0;
    i_clr = 1;
    tick();
    i_clr = 0;
  endtask

  // Feeds nb beats to all instances, then tail idle cycles, recording every d9 output.
  task automatic stream(input int g0, input int nb, input bit big, input int tail);
    cnt9 = 0;
    for (int k = 0; k < nb + tail; k++) begin
      if (k >= nb) i_valid = 0;
      else if (big) present(pack3(127, 127, 127), pack3(127, 127, 127), 0);
      else present(pack3(k % 9 + 1, g0 + k / 9, -1), pack3(2, 3, 4), 100 * (g0 + k / 9));
      tick();
      if (o_valid[2]) begin
        if (cnt9 < 8) begin
          vals9[cnt9] = od[2];
          sats9[cnt9] = o_sat[2];
          idx9[cnt9] = k;
        end
        cnt9++;
      end
    end
    i_valid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1);
  end

  initial begin
    int n, c1, v1[8], s1[8];
    tbl[0] = '{pack3(1, 2, 3), pack3(4, 5, 6), pack3(-1, -1, -1), pack3(1, 1, 1), 10, 39, 0, 39, 0};
    tbl[1] = '{pack3(1, 2, 3), pack3(4, 5, 6), pack3(-1, -1, -1), pack3(1, 1, 1), -50, 0, 0, -21, 0};
    tbl[2] = '{pack3(127, 127, 127), pack3(127, 127, 127), pack3(127, 127, 127), pack3(127, 127, 127), 0, 32767, 1, 32767, 1};
    tbl[3] = '{pack3(-128, -128, -128), pack3(127, 127, 127), pack3(-128, -128, -128), pack3(127, 127, 127), 0, 0, 0, -32768, 1};
    tbl[4] = '{pack3(10, 0, 0), pack3(10, 0, 0), pack3(0, 5, 0), pack3(0, -3, 0), 7, 92, 0, 92, 0};
    tbl[5] = '{pack3(-5, 6, 7), pack3(8, -9, 10), pack3(2, 2, 2), pack3(-2, -2, -2), 36, 0, 0, 0, 0};

    tick();
    tick();
    chk("rst o_valid", o_valid[0], 0);
    chk("rst o_data", od[0], 0);
    chk("rst o_sat", o_sat[0], 0);
    reset_n = 1;
    chk("rst i_ready", i_ready[0], 1);

    for (int i = 0; i < 6; i++) begin
      clr_pulse();
      present(tbl[i].d1, tbl[i].w1, tbl[i].bias);
      tick();
      present(tbl[i].d2, tbl[i].w2, 999);
      tick();
      i_valid = 0;
      n = 1;
      while (!o_valid[0] && n < 10) begin
        tick();
        n++;
      end
      chk($sformatf("vec%0d latency", i), n, 3);
      chk($sformatf("vec%0d relu data", i), od[0], tbl[i].e_r);
      chk($sformatf("vec%0d relu sat", i), o_sat[0], tbl[i].s_r);
      chk($sformatf("vec%0d norelu data", i), od[1], tbl[i].e_n);
      chk($sformatf("vec%0d norelu sat", i), o_sat[1], tbl[i].s_n);
    end

    clr_pulse();
    o_ready = 0;
    present(tbl[0].d1, tbl[0].w1, 10);
    tick();
    present(tbl[0].d2, tbl[0].w2, 999);
    tick();
    present(tbl[4].d1, tbl[4].w1, 7);
    tick();
    present(tbl[4].d2, tbl[4].w2, 999);
    tick();
    present(pack3(1, 1, 1), pack3(1, 1, 1), 0);
    for (int i = 0; i < 6; i++) begin
      chk("stall i_ready", i_ready[0], 0);
      chk("stall o_valid", o_valid[0], 1);
      chk("stall o_data", od[0], 39);
      tick();
    end
    i_valid = 0;
    o_ready = 1;
    tick();
    chk("handshake drop", o_valid[0], 0);
    n = 0;
    while (!o_valid[0] && n < 10) begin
      tick();
      n++;
    end
    chk("after stall data", od[0], 92);

    clr_pulse();
    c1 = 0;
    for (int k = 0; k < 9; k++) begin
      if (k == 0) present(pack3(1, 2, 3), pack3(4, 5, 6), 10);
      else if (k == 1) present(pack3(-1, -1, -1), pack3(1, 1, 1), -50);
      else if (k == 2) present(pack3(127, 127, 127), pack3(127, 127, 127), 0);
      else i_valid = 0;
      tick();
      if (o_valid[3]) begin
        if (c1 < 8) begin
          v1[c1] = od[3];
          s1[c1] = o_sat[3];
        end
        c1++;
      end
    end
    chk("taps1 count", c1, 3);
    chk("taps1 out0", v1[0], 42);
    chk("taps1 out1", v1[1], 0);
    chk("taps1 out2", v1[2], 32767);
    chk("taps1 sat2", s1[2], 1);

    clr_pulse();
    stream(0, 27, 0, 6);
    chk("stream count", cnt9, 3);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("stream out%0d", g), vals9[g], expg(g));
      chk($sformatf("stream sat%0d", g), sats9[g], 0);
    end
    chk("stream first idx", idx9[0], 10);
    chk("stream gap0", idx9[1] - idx9[0], 9);
    chk("stream gap1", idx9[2] - idx9[1], 9);

    clr_pulse();
    stream(0, 9, 1, 6);
    chk("sat9 count", cnt9, 1);
    chk("sat9 data", vals9[0], 32767);
    chk("sat9 flag", sats9[0], 1);

    stream(3, 5, 0, 0);
    chk("partial no out", cnt9, 0);
    clr_pulse();
    stream(1, 9, 0, 6);
    chk("clr count", cnt9, 1);
    chk("clr data", vals9[0], expg(1));

    stream(2, 5, 0, 0);
    reset_n = 0;
    #2;
    chk("async rst o_valid", o_valid[2], 0);
    tick();
    reset_n = 1;
    stream(2, 9, 0, 6);
    chk("reset count", cnt9, 1);
    chk("reset data", vals9[0], expg(2));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cnn_mac_acc.md
CNN_MAC_ACC -- requirements
Module: cnn_mac_acc

Interface
REQ-001 The block SHALL have parameter CI, default 3, input channel count (>=2).
REQ-002 The block SHALL have parameter IN_BW, default 8, signed feature width per channel.
REQ-003 The block SHALL have parameter W_BW, default 8, signed weight width per channel.
REQ-004 The block SHALL have parameter TAPS, default 9, accepted beats accumulated per output (>=1).
REQ-005 The block SHALL have parameter BIAS_BW, default 16, signed bias width.
REQ-006 The block SHALL have parameter OUT_BW, default 16, signed output width.
REQ-007 The block SHALL have parameter RELU_EN, default 1; 1 = ReLU applied, 0 = bypass.
REQ-008 The block SHALL have port clk, input, 1, clock; all logic on the rising edge.
REQ-009 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-010 The block SHALL have port i_clr, input, 1, synchronous soft clear.
REQ-011 The block SHALL have port i_valid, input, 1, input beat valid.
REQ-012 The block SHALL have port i_ready, output, 1, input beat accepted when i_valid & i_ready.
REQ-013 The block SHALL have port i_data, input, CI*IN_BW, packed features, channel c at [c*IN_BW +: IN_BW].
REQ-014 The block SHALL have port i_weight, input, CI*W_BW, packed weights, same packing.
REQ-015 The block SHALL have port i_bias, input, BIAS_BW, per-output bias.
REQ-016 The block SHALL have port o_valid, output, 1, result valid.
REQ-017 The block SHALL have port o_ready, input, 1, downstream accepts when o_valid & o_ready.
REQ-018 The block SHALL have port o_data, output, OUT_BW, signed result.
REQ-019 The block SHALL have port o_sat, output, 1, high with o_data when saturation clipped the result.

Function
REQ-020 Widths SHALL be MUL_BW=IN_BW+W_BW, SUM_BW=MUL_BW+clog2(CI), ACC_BW=max(SUM_BW+clog2(TAPS)+1, BIAS_BW+1); all arithmetic signed and sign-extended.
REQ-021 A global enable en SHALL equal !o_valid | o_ready; i_ready SHALL equal en & !i_clr.
REQ-022 Stage 1 SHALL register CI products and a valid bit when en; the valid bit SHALL be the accept condition.
REQ-023 Stage 2 SHALL register the CI-product sum (SUM_BW) and a valid bit when en.
REQ-024 Stage 3 SHALL, on a valid stage-2 beat with en, add the sum to the accumulator and increment a tap counter 0..TAPS-1.
REQ-025 On tap 0 the accumulator SHALL load the sum, not add it to the previous value.
REQ-026 i_bias SHALL be latched on acceptance of the beat that will become tap 0.
REQ-027 On tap TAPS-1 the output register SHALL load sat(relu(acc+sum+bias)), o_valid SHALL rise, the counter SHALL wrap to 0 and the accumulator SHALL not be written.
REQ-028 relu SHALL map negative values to 0 when RELU_EN=1; sat SHALL clip to [-2^(OUT_BW-1), 2^(OUT_BW-1)-1] and set o_sat when clipping occurs.
REQ-029 Latency from acceptance of the last tap to o_valid SHALL be 3 cycles when unstalled; throughput SHALL be one beat per cycle.
REQ-030 When en=0 all stages, the counter, the accumulator and o_data SHALL hold; o_data/o_sat SHALL be stable while o_valid & !o_ready.
REQ-031 o_valid SHALL fall after handshake unless a new result loads in the same cycle (back-to-back outputs).
REQ-032 i_clr SHALL clear the stage valid bits, the tap counter and o_valid on the next edge, and has priority over all updates; in-flight taps SHALL be discarded.
REQ-033 For TAPS=1, every accepted beat SHALL produce one output.

Reset
REQ-034 Asynchronous reset SHALL clear all stage valid bits, products, sums, accumulator, counter and latched bias to 0, and SHALL force o_valid=0, o_data=0, o_sat=0; after release, i_ready=1.
REQ-035 Reset asserted mid-accumulation SHALL discard partial taps; the first beat after release SHALL be tap 0.

Verification
REQ-036 CI=3, TAPS=2, bias=10: beat (1,2,3)x(4,5,6), then (-1,-1,-1)x(1,1,1) -> o_data=39, o_sat=0, o_valid 3 cycles after beat 2.
REQ-037 Same as REQ-036 with bias=-50, RELU_EN=1 -> o_data=0; with RELU_EN=0 -> o_data=-21.
REQ-038 CI=3, TAPS=9, OUT_BW=16: all data=127, weights=127, bias=0 -> o_data=32767, o_sat=1.
REQ-039 Hold o_ready=0 with a result pending and i_valid=1 for 6 cycles -> i_ready=0, o_data stable, no beats lost; release -> next result correct.
REQ-040 Continuous i_valid, o_ready=1, TAPS=9, 27 beats -> exactly 3 outputs, each correct, spaced 9 cycles apart.
REQ-041 Assert reset_n or i_clr after tap 4 of 9, resume with 9 fresh beats -> single output equal to the sum of the fresh beats plus bias only.
